alu_operand_feeder: RTL and testbench

ALU_OPERAND_FEEDER -- requirements
Module: alu_operand_feeder

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_operand_feeder_if.sv | 42 ++++
 rtl/alu_cmd_fifo.sv | 60 ++++++
 rtl/alu_operand_feeder.sv | 136 +++++++++++++
 tb/tb_alu_operand_feeder.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// alu_pkg : ALU opcodes, feeder FSM encoding, command record, defaults
// Revision: 1.0
// ---------------------------------------------------------------
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_INC  = 3'd3;
  localparam logic [2:0] OP_DEC  = 3'd4;
  localparam logic [2:0] OP_PASS = 3'd5;
  localparam logic [2:0] OP_OR   = 3'd6;
  localparam logic [2:0] OP_AND  = 3'd7;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_TMO   = 15;
  localparam int CMD_W     = 67;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

endpackage
`default_nettype wire

// File: rtl/alu_operand_feeder_if.sv
`default_nettype none
// ---------------------------------------------------------------
// alu_operand_feeder_if : command, ALU and result channels of the feeder
// Revision: 1.0
// ---------------------------------------------------------------
interface alu_operand_feeder_if;

  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_opcode;
  logic [31:0] in_a;
  logic [31:0] in_b;

  logic        alu_e;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  logic        alu_ack;

  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [2:0]  res_opcode;
  logic        res_err;

  // feeder side
  modport slave (
    input  in_valid, in_opcode, in_a, in_b, alu_y, alu_ack, res_ready,
    output in_ready, alu_e, alu_opcode, alu_a, alu_b,
    output res_valid, res_data, res_opcode, res_err
  );

  // producer / ALU / consumer side
  modport master (
    output in_valid, in_opcode, in_a, in_b, alu_y, alu_ack, res_ready,
    input  in_ready, alu_e, alu_opcode, alu_a, alu_b,
    input  res_valid, res_data, res_opcode, res_err
  );

endinterface
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ---------------------------------------------------------------
// alu_cmd_fifo : DEPTH-entry synchronous FIFO with head visible on dout
// Revision: 1.0
// ---------------------------------------------------------------
module alu_cmd_fifo #(
  parameter int WIDTH = 67,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= din;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_operand_feeder.sv
`default_nettype none
// ---------------------------------------------------------------
// alu_operand_feeder : queues ALU commands, issues them one at a time,
// captures results or flags an ack timeout.   Revision: 1.0
// ---------------------------------------------------------------
module alu_operand_feeder
  import alu_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int TMO   = DEF_TMO
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_operand_feeder_if.slave  bus
);

  localparam int CNT_W = $clog2(TMO + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO - 1);

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;

  logic             alu_e_q;
  logic [2:0]       alu_op_q;
  logic [31:0]      alu_a_q;
  logic [31:0]      alu_b_q;
  logic             res_valid_q;
  logic             res_err_q;
  logic [31:0]      res_data_q;
  logic [2:0]       res_op_q;

  cmd_t             in_cmd;
  cmd_t             head;
  cmd_t             issue_cmd;
  logic [CMD_W-1:0] head_bits;
  logic             fifo_full;
  logic             fifo_empty;
  logic             accept;
  logic             bypass;
  logic             fifo_push;
  logic             fifo_pop;

  assign in_cmd = {bus.in_opcode, bus.in_a, bus.in_b};
  assign head   = cmd_t'(head_bits);
  assign accept = bus.in_valid && !fifo_full;

  // An idle feeder with nothing queued issues the incoming command at the
  // push edge itself, giving the two-cycle push-to-result latency.
  assign bypass    = (state == ST_IDLE) && fifo_empty && accept;
  assign fifo_push = accept && !bypass;
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
  assign issue_cmd = fifo_empty ? in_cmd : head;

  alu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (in_cmd),
    .dout  (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      tmo_cnt     <= '0;
      alu_e_q     <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_pop || bypass) begin
            alu_op_q <= issue_cmd.opcode;
            alu_a_q  <= issue_cmd.a;
            alu_b_q  <= issue_cmd.b;
            tmo_cnt  <= '0;
            alu_e_q  <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // tmo_cnt == 0 marks the first ISSUE cycle, where a leftover ack is ignored
          if ((tmo_cnt != '0) && bus.alu_ack) begin
            res_data_q  <= bus.alu_y;
            res_op_q    <= alu_op_q;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b1;
            alu_e_q     <= 1'b0;
            state       <= ST_RESULT;
          end else if (tmo_cnt == CNT_LAST) begin
            res_data_q  <= '0;
            res_op_q    <= alu_op_q;
            res_err_q   <= 1'b1;
            res_valid_q <= 1'b1;
            alu_e_q     <= 1'b0;
            state       <= ST_RESULT;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        ST_RESULT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = !fifo_full;
  assign bus.alu_e      = alu_e_q;
  assign bus.alu_opcode = alu_op_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_opcode = res_op_q;
  assign bus.res_err    = res_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_feeder.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_alu_operand_feeder : vector table, corner sequences and random traffic
// checked by an in-order scoreboard.   Revision: 1.0
// ---------------------------------------------------------------
module tb_alu_operand_feeder;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   ack_mode = 0;   // 0: ack after ack_lat cycles, 1: never, 2: tied high
  int   ack_lat = 1;
  int   icnt = 0;

  typedef struct { logic [2:0] op; logic [31:0] a; logic [31:0] b; } cmd_s;
  typedef struct { logic [2:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] y; } vec_t;

  cmd_s exp_q[$];
  cmd_s sb_c;
  vec_t tbl [10];

  alu_operand_feeder_if bus ();

  alu_operand_feeder #(.DEPTH(4), .TMO(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return ~a;
      3'd3:    return a + 32'd1;
      3'd4:    return a - 32'd1;
      3'd5:    return a;
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // behavioural ALU
  always @(posedge clk) icnt <= bus.alu_e ? icnt + 1 : 0;

  always_comb begin
    bus.alu_y = ref_alu(bus.alu_opcode, bus.alu_a, bus.alu_b);
    case (ack_mode)
      0:       bus.alu_ack = bus.alu_e && (icnt >= ack_lat);
      1:       bus.alu_ack = 1'b0;
      default: bus.alu_ack = 1'b1;
    endcase
  end

  // in-order scoreboard: every accepted command must come back exactly once
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_result", 32'd1, 32'd0);
        end else begin
          sb_c = exp_q.pop_front();
          check("sb_data", bus.res_data, (ack_mode == 1) ? 32'd0 : ref_alu(sb_c.op, sb_c.a, sb_c.b));
          check("sb_opcode", {29'd0, bus.res_opcode}, {29'd0, sb_c.op});
          check("sb_err", {31'd0, bus.res_err}, (ack_mode == 1) ? 32'd1 : 32'd0);
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back('{bus.in_opcode, bus.in_a, bus.in_b});
    end
  end

  task automatic push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    bus.in_valid = 1'b1; bus.in_opcode = op; bus.in_a = a; bus.in_b = b;
    while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
    if (!bus.in_ready) check("push_stuck", 32'd0, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_one(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int ecyc, output logic [31:0] d,
                         output logic [2:0] o, output logic e, output logic er);
    push(op, a, b);
    lat = 0; ecyc = 0;
    while (!bus.res_valid && lat < 60) begin
      if (bus.alu_e) ecyc++;
      @(negedge clk); lat++;
    end
    d = bus.res_data; o = bus.res_opcode; e = bus.alu_e; er = bus.res_err;
    check("res_valid_seen", {31'd0, bus.res_valid}, 32'd1);
    bus.res_ready = 1'b1; @(negedge clk); bus.res_ready = 1'b0;
    check("res_valid_drop", {31'd0, bus.res_valid}, 32'd0);
  endtask

  task automatic collect(input string nm, input logic [31:0] ed, input logic [2:0] eo);
    int n = 0;
    while (!bus.res_valid && n < 60) begin @(negedge clk); n++; end
    check({nm, "_valid"}, {31'd0, bus.res_valid}, 32'd1);
    check({nm, "_data"}, bus.res_data, ed);
    check({nm, "_op"}, {29'd0, bus.res_opcode}, {29'd0, eo});
    bus.res_ready = 1'b1; @(negedge clk); bus.res_ready = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    bus.res_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.res_valid) && n < 400) begin @(negedge clk); n++; end
    bus.res_ready = 1'b0;
    check(nm, exp_q.size(), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ecyc, nrv;
    logic [31:0] d;
    logic [2:0] o;
    logic e, er;

    bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_a = '0; bus.in_b = '0; bus.res_ready = 1'b0;
    tbl[0] = '{OP_ADD,  32'd5,         32'd3,         32'd8};
    tbl[1] = '{OP_SUB,  32'd10,        32'd4,         32'd6};
    tbl[2] = '{OP_OR,   32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF};
    tbl[3] = '{OP_NOT,  32'd0,         32'h1234_5678, 32'hFFFF_FFFF};
    tbl[4] = '{OP_INC,  32'hFFFF_FFFF, 32'd7,         32'd0};
    tbl[5] = '{OP_DEC,  32'd0,         32'd0,         32'hFFFF_FFFF};
    tbl[6] = '{OP_PASS, 32'hDEAD_BEEF, 32'd1,         32'hDEAD_BEEF};
    tbl[7] = '{OP_AND,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000};
    tbl[8] = '{OP_ADD,  32'hFFFF_FFFF, 32'd1,         32'd0};
    tbl[9] = '{OP_SUB,  32'd0,         32'd1,         32'hFFFF_FFFF};

    // reset values
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_alu_e", {31'd0, bus.alu_e}, 32'd0);
    check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("rst_res_err", {31'd0, bus.res_err}, 32'd0);
    check("rst_res_data", bus.res_data, 32'd0);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_alu_op", {29'd0, bus.alu_opcode}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single op: result two edges after push, two ISSUE cycles
    ack_mode = 0; ack_lat = 1;
    run_one(OP_ADD, 32'd5, 32'd3, lat, ecyc, d, o, e, er);
    check("single_data", d, 32'd8);
    check("single_op", {29'd0, o}, 32'd0);
    check("single_err", {31'd0, er}, 32'd0);
    check("single_latency", lat, 32'd2);
    check("single_issue_cycles", ecyc, 32'd2);

    // vector table
    for (int i = 0; i < 10; i++) begin
      run_one(tbl[i].op, tbl[i].a, tbl[i].b, lat, ecyc, d, o, e, er);
      check($sformatf("vec%0d_data", i), d, tbl[i].y);
      check($sformatf("vec%0d_op", i), {29'd0, o}, {29'd0, tbl[i].op});
      check($sformatf("vec%0d_err", i), {31'd0, er}, 32'd0);
    end

    // ordering of queued commands
    push(OP_SUB, 32'd10, 32'd4);
    push(OP_OR, 32'hF0, 32'h0F);
    push(OP_NOT, 32'd0, $urandom());
    collect("order0", 32'd6, OP_SUB);
    collect("order1", 32'hFF, OP_OR);
    collect("order2", 32'hFFFF_FFFF, OP_NOT);

    // backpressure: 1 in flight + 4 queued fills the feeder
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_ready_%0d", i), {31'd0, bus.in_ready}, 32'd1);
      push(OP_ADD, i, 32'd100);
    end
    check("bp_full", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b1; bus.in_opcode = OP_SUB; bus.in_a = 32'd50; bus.in_b = 32'd8;
    repeat (4) @(negedge clk);
    check("bp_stall", {31'd0, bus.in_ready}, 32'd0);
    check("bp_first_valid", {31'd0, bus.res_valid}, 32'd1);
    check("bp_first_data", bus.res_data, 32'd100);
    bus.res_ready = 1'b1; @(negedge clk); bus.res_ready = 1'b0;
    push(OP_SUB, 32'd50, 32'd8);
    drain("bp_drain");

    // ack timeout, then a normal command
    ack_mode = 1;
    run_one(OP_INC, 32'd41, 32'd0, lat, ecyc, d, o, e, er);
    check("tmo_issue_cycles", ecyc, 32'd15);
    check("tmo_err", {31'd0, er}, 32'd1);
    check("tmo_data", d, 32'd0);
    check("tmo_alu_e_low", {31'd0, e}, 32'd0);
    ack_mode = 0;
    run_one(OP_DEC, 32'd41, 32'd0, lat, ecyc, d, o, e, er);
    check("post_tmo_data", d, 32'd40);
    check("post_tmo_err", {31'd0, er}, 32'd0);

    // ack stuck high
    ack_mode = 2;
    run_one(OP_ADD, 32'd7, 32'd9, lat, ecyc, d, o, e, er);
    check("stale1_cycles", ecyc, 32'd2);
    check("stale1_data", d, 32'd16);
    run_one(OP_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, lat, ecyc, d, o, e, er);
    check("stale2_cycles", ecyc, 32'd2);
    check("stale2_data", d, 32'h0F00_0F00);

    // reset with one in flight and three queued
    ack_mode = 1;
    for (int i = 0; i < 4; i++) push(OP_ADD, i + 10, i);
    check("rst_mid_busy", {31'd0, bus.alu_e}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_alu_e", {31'd0, bus.alu_e}, 32'd0);
    check("rst_mid_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_mid_alu_a", bus.alu_a, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nrv = 0;
    repeat (6) begin @(negedge clk); if (bus.res_valid || bus.alu_e) nrv++; end
    check("rst_no_activity", nrv, 32'd0);
    check("rst_post_ready", {31'd0, bus.in_ready}, 32'd1);
    ack_mode = 0;
    run_one(OP_ADD, 32'd100, 32'd23, lat, ecyc, d, o, e, er);
    check("rst_post_data", d, 32'd123);
    check("rst_post_latency", lat, 32'd2);

    // random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.in_opcode = 3'($urandom_range(0, 7));
      bus.in_a      = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
      bus.in_b      = $urandom();
      bus.res_ready = ($urandom_range(0, 1) != 0);
      ack_lat       = $urandom_range(1, 4);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    drain("rand_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
